uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the SoC's serial console: it is the receive-side counterpart of the `io_tx` transmitter on `Top`. It oversamples an asynchronous `rx` line with the system clock and recovers 8N1 frames, LSB first. Each byte goes to the CPU-side peripheral through a one-entry valid/ready holding register, with framing and overrun reporting. It also lets the simulation bench loop `io_tx` back to check the transmitter end-to-end.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz (20 ns period).
- `BAUD_RATE`, 115200: line bit rate.
- Derived: `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer truncation; 434 at defaults). Must be ≥ 8.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous serial input; idle high.
- `data_out` out 8: received byte; stable while `data_valid`.
- `data_valid` out 1: holding register full.
- `data_ready` in 1: consumer accepts the byte on a cycle where `data_valid && data_ready`.
- `frame_err` out 1: one-cycle pulse; stop bit sampled low.
- `overrun` out 1: one-cycle pulse; a new byte completed while the holding register was full and not draining.
- `busy` out 1: high in every state except IDLE and WAIT_IDLE.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- **Bit counter.** `cnt` is ⌈log2(CLKS_PER_BIT)⌉ bits wide. It clears on every state transition.
- **Bit index.** `bit_idx` is 3 bits.
- **WAIT_IDLE.** Reset state. Go to IDLE on the first cycle `rx_s == 1`. This means a line held low across reset release is never taken as a start bit.
- **IDLE.** On `rx_s == 0`, go to START.
- **START.**
  - At `cnt == CLKS_PER_BIT/2 - 1`, sample `rx_s`.
  - If it is 0, go to DATA with `bit_idx = 0`.
  - If it is 1 (a glitch), go back to IDLE with no error reported.
- **DATA.**
  - At `cnt == CLKS_PER_BIT - 1`, shift `rx_s` into bit 7 of the shift register (right shift).
  - When `bit_idx == 7`, go to PARITY if enabled, else STOP. Otherwise increment `bit_idx`.
- **STOP.** At `cnt == CLKS_PER_BIT - 1`, sample `rx_s`:
  - If 1: deliver the byte (see below) and go to IDLE. Re-arming at mid-stop-bit tolerates up to ½ bit of clock skew.
  - If 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE. A break condition therefore produces exactly one `frame_err`.
- **Delivery.**
  - If `!data_valid` or `data_ready` on that cycle: load `data_out` and set `data_valid`. Simultaneous accept and load keeps `data_valid` high with no bubble.
  - Otherwise: pulse `overrun`, drop the new byte, keep the old one.
- **Acceptance.** `data_valid && data_ready` with no new delivery clears `data_valid`. `data_out` holds its last value.
- **Reset mid-frame.** Abandons the partial byte, clears the holding register, and returns to WAIT_IDLE.

## Timing
- **Reset values:** `data_out = 0`, `data_valid = 0`, `frame_err = 0`, `overrun = 0`, `busy = 0`. Synchronizer flops = 1. State = WAIT_IDLE.
- **Start detection:** 2 cycles after the falling edge on `rx`, from the synchronizer. START is entered 3 cycles after the edge.
- **Sample points** (measured from entering START):
  - start bit: cycle `CLKS_PER_BIT/2`;
  - data bit k: `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT`;
  - stop bit: `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT`.
- **`data_valid`** rises the cycle after the stop-bit sample. This is about 9.5 bit times plus 3 cycles after the start edge.
- **Pulse width:** `frame_err` and `overrun` are registered and exactly one cycle wide.
- **Back-to-back frames:** a start edge arriving at or after the stop-bit sample is accepted without loss.

## Configuration
- **`UART_RX_PARITY_EN`** defined:
  - Adds a PARITY state between DATA and STOP, expecting even parity over the 8 data bits.
  - Adds output `parity_err` (1 bit, reset 0), a one-cycle pulse raised at the stop-bit decision.
  - A byte with a parity mismatch is dropped even if its stop bit is good. `frame_err` takes priority if both errors occur.
  - All stop-bit sample points shift by one bit time.
- **`UART_RX_PARITY_EN`** undefined: 8N1 only. No PARITY state and no `parity_err` port.

## Structure
- **Shared package `uart_pkg`:** state enum (WAIT_IDLE, IDLE, START, DATA, PARITY, STOP), `UART_DATA_BITS = 8`, default `CLK_FREQ`/`BAUD_RATE` constants. The future `uart_tx` rewrite shares these.
- **Sub-module `uart_bit_timer`:** counter with `clear` input, `half` and `full` tick outputs, parameterized by `CLKS_PER_BIT`. The FSM and holding register stay in `uart_rx`.

## Test plan
All scenarios run at default parameters.
- **Single byte:** send 0xA5 (8N1) then idle. Expect `data_valid` with `data_out = 0xA5`, rising 9.5 bit times + 3 cycles after the start edge. `frame_err = 0`.
- **Glitch:** hold `rx` low for 100 cycles, then high. Expect no `data_valid`, no `frame_err`, and `busy` back to 0 by cycle 220.
- **Framing error:** send 0x3C with the stop bit low, then idle high. Expect one `frame_err` pulse and no `data_valid`. A following 0x5A is received correctly.
- **Overrun:** with `data_ready = 0`, send 0x11 then 0x22 back-to-back. Expect `data_out = 0x11` held and one `overrun` pulse. Then with `data_ready = 1` asserted exactly on the cycle 0x33 completes, expect `data_out = 0x33` and `data_valid` continuously high.
- **Reset mid-frame:** assert `reset` during bit 4 of 0xFF, release while `rx` is low. Expect no false start until `rx` returns high. The next byte 0x81 is received intact.
- **Parity (`UART_RX_PARITY_EN`):** send 0x07 with parity bit 1, then 0x07 with parity bit 0. Expect the first delivered; the second dropped with `parity_err` pulsed once.

Source files
------------

// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Constants and FSM state codes shared by the UART blocks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_CLK_FREQ  = 50_000_000;
    localparam int UART_BAUD_RATE = 115_200;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_WAIT_IDLE = 3'd0;
    localparam uart_state_t ST_IDLE      = 3'd1;
    localparam uart_state_t ST_START     = 3'd2;
    localparam uart_state_t ST_DATA      = 3'd3;
    localparam uart_state_t ST_PARITY    = 3'd4;
    localparam uart_state_t ST_STOP      = 3'd5;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
//==============================================================================
// Module      : uart_bit_timer
// Description : Bit-period counter with half-bit and full-bit ticks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic half,
    output logic full
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wrapping on the full tick lets consecutive data bits share one state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear || full) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign half = (r_cnt == c_half);
    assign full = (r_cnt == c_full);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//==============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 UART receiver with a one-entry valid/ready
//               holding register; optional even parity via UART_RX_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = UART_CLK_FREQ,
    parameter int BAUD_RATE = UART_BAUD_RATE
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      parity_err
`endif
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    logic                      r_rx_meta;
    logic                      r_rx_s;
    logic [1:0]                r_sync_fill;
    uart_state_t               r_state;
    uart_state_t               w_state_next;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      r_ovr;
    logic                      w_half;
    logic                      w_full;
    logic                      w_clear;
    logic                      w_sync_ok;
    logic                      w_stop_tick;
    logic                      w_deliver;
    logic                      w_load;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bit;
    logic                      r_perr;
    logic                      w_par_bad;
`endif

    // The synchronizer's reset value is not a line sample, so WAIT_IDLE
    // only trusts rx_s once real samples have reached the second flop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_sync_fill <= 2'b00;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
        end
    end

    assign w_sync_ok = r_sync_fill[1];

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .clear(w_clear),
        .half (w_half),
        .full (w_full)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_IDLE: if (w_sync_ok && r_rx_s) w_state_next = ST_IDLE;
            ST_IDLE:      if (!r_rx_s) w_state_next = ST_START;
            ST_START:     if (w_half) w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:      if (w_full && (r_bit_idx == 3'd7)) w_state_next = ST_PARITY;
            ST_PARITY:    if (w_full) w_state_next = ST_STOP;
`else
            ST_DATA:      if (w_full && (r_bit_idx == 3'd7)) w_state_next = ST_STOP;
`endif
            ST_STOP:      if (w_full) w_state_next = r_rx_s ? ST_IDLE : ST_WAIT_IDLE;
            default:      w_state_next = ST_WAIT_IDLE;
        endcase
    end

    assign w_clear     = (w_state_next != r_state);
    assign w_stop_tick = (r_state == ST_STOP) && w_full;
`ifdef UART_RX_PARITY_EN
    assign w_par_bad   = ^{r_shift, r_par_bit};
    assign w_deliver   = w_stop_tick && r_rx_s && !w_par_bad;
`else
    assign w_deliver   = w_stop_tick && r_rx_s;
`endif
    assign w_load      = w_deliver && (!r_valid || data_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_WAIT_IDLE;
            r_bit_idx <= 3'd0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_ferr  <= w_stop_tick && !r_rx_s;
            r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= w_stop_tick && r_rx_s && w_par_bad;
            if ((r_state == ST_PARITY) && w_full) r_par_bit <= r_rx_s;
`endif
            if (r_state != ST_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_full) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
            end
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_deliver) begin
                r_ovr   <= 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != ST_WAIT_IDLE) && (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (table vectors, corner
//               sequences, randomized frames against a byte queue model).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = UART_CLK_FREQ / UART_BAUD_RATE;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edge (counted from the start edge) on which the stop bit is judged.
    localparam int DEC = 3 + CPB / 2 + (NB - 1) * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #10 clock = ~clock;

    int total = 0;
    int bad = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    bit rand_mode = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] make_frame(input logic [7:0] d, input logic stop_v);
        logic [NB-1:0] f;
        f      = '0;
        f[8:1] = d;
`ifdef UART_RX_PARITY_EN
        f[9]   = ^d;
`endif
        f[NB-1] = stop_v;
        return f;
    endfunction

    task automatic send_bits(input logic [NB-1:0] f);
        @(posedge clock); #1;
        for (int i = 0; i < NB; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        n_ferr = n_ferr + int'(frame_err);
        n_ovr  = n_ovr + int'(overrun);
`ifdef UART_RX_PARITY_EN
        n_perr = n_perr + int'(parity_err);
`endif
        if (rand_mode && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rand_extra: got byte %02h want none", data_out);
            end else begin
                check8("rand_byte", data_out, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    // Sends one vector and checks the exact delivery edge and pulse width.
    task automatic run_vector(input vec_t v);
        fork
            send_bits(make_frame(v.data, v.stop));
            begin
                @(posedge clock);
                repeat (DEC - 1) @(posedge clock);
                #1;
                check1("vec_early_valid", data_valid, 1'b0);
                @(posedge clock); #1;
                check1("vec_valid", data_valid, v.exp_valid);
                check1("vec_frame_err", frame_err, v.exp_ferr);
                if (v.exp_valid) check8("vec_data", data_out, v.data);
                @(posedge clock); #1;
                check1("vec_ferr_width", frame_err, 1'b0);
            end
        join
        if (data_valid) begin
            data_ready = 1'b1;
            idle(1);
            data_ready = 1'b0;
        end
        check1("vec_drained", data_valid, 1'b0);
        idle(5);
    endtask

    initial begin
        repeat (150000) @(posedge clock);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int  f0;
        int  o0;
        int  p0;
        int  exp_ferr;
        bit  all_hi;
        bit  any_busy;
        logic [7:0] d;
        logic       good;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1};

        idle(5);
        check8("rst_data_out", data_out, 8'h00);
        check1("rst_valid", data_valid, 1'b0);
        check1("rst_frame_err", frame_err, 1'b0);
        check1("rst_overrun", overrun, 1'b0);
        check1("rst_busy", busy, 1'b0);
        reset = 1'b1;
        idle(10);

        for (int i = 0; i < 5; i++) begin
            f0 = n_ferr;
            run_vector(vecs[i]);
            checkn("vec_ferr_count", n_ferr - f0, int'(vecs[i].exp_ferr));
        end

        // Short low pulse: start bit rejected at mid-bit.
        f0 = n_ferr;
        @(posedge clock); #1;
        rx = 1'b0;
        idle(50);
        check1("glitch_busy_mid", busy, 1'b1);
        idle(50);
        rx = 1'b1;
        idle(130);
        check1("glitch_busy_end", busy, 1'b0);
        check1("glitch_valid", data_valid, 1'b0);
        checkn("glitch_ferr", n_ferr - f0, 0);
        idle(10);

        // Overrun, then load on the same cycle as acceptance.
        o0 = n_ovr;
        send_bits(make_frame(8'h11, 1'b1));
        send_bits(make_frame(8'h22, 1'b1));
        check1("ovr_valid", data_valid, 1'b1);
        check8("ovr_data_held", data_out, 8'h11);
        checkn("ovr_pulses", n_ovr - o0, 1);
        all_hi = 1'b1;
        fork
            send_bits(make_frame(8'h33, 1'b1));
            begin
                @(posedge clock);
                for (int i = 1; i < DEC; i++) begin
                    @(posedge clock); #1;
                    all_hi &= data_valid;
                end
                data_ready = 1'b1;
                @(posedge clock); #1;
                data_ready = 1'b0;
                all_hi &= data_valid;
            end
        join
        idle(2);
        check8("swap_data", data_out, 8'h33);
        check1("swap_no_bubble", all_hi, 1'b1);
        checkn("swap_no_overrun", n_ovr - o0, 1);
        idle(5);

        // Reset in bit 4 of 0xFF, released with the line held low.
        f0 = n_ferr;
        @(posedge clock); #1;
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(4 * CPB + CPB / 2);
        check1("mid_busy", busy, 1'b1);
        reset = 1'b0;
        rx = 1'b0;
        idle(5);
        check1("mid_rst_valid", data_valid, 1'b0);
        check8("mid_rst_data", data_out, 8'h00);
        check1("mid_rst_busy", busy, 1'b0);
        reset = 1'b1;
        any_busy = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            idle(1);
            any_busy |= busy;
        end
        check1("mid_no_false_start", any_busy, 1'b0);
        checkn("mid_no_ferr", n_ferr - f0, 0);
        rx = 1'b1;
        idle(10);
        run_vector('{8'h81, 1'b1, 1'b1, 1'b0});

        // Randomized frames with an always-ready consumer.
        data_ready = 1'b1;
        rand_mode  = 1'b1;
        f0 = n_ferr;
        exp_ferr = 0;
        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            if (good) exp_q.push_back(d);
            else exp_ferr++;
            send_bits(make_frame(d, good));
            idle($urandom_range(3, 40));
        end
        idle(10);
        rand_mode  = 1'b0;
        data_ready = 1'b0;
        checkn("rand_left", exp_q.size(), 0);
        checkn("rand_ferr", n_ferr - f0, exp_ferr);

`ifdef UART_RX_PARITY_EN
        p0 = n_perr;
        send_bits(make_frame(8'h07, 1'b1));
        idle(5);
        check1("par_ok_valid", data_valid, 1'b1);
        check8("par_ok_data", data_out, 8'h07);
        data_ready = 1'b1;
        idle(1);
        data_ready = 1'b0;
        begin
            logic [NB-1:0] fb;
            fb = make_frame(8'h07, 1'b1);
            fb[9] = ~fb[9];
            send_bits(fb);
        end
        idle(5);
        check1("par_bad_valid", data_valid, 1'b0);
        checkn("par_err_pulses", n_perr - p0, 1);
`else
        p0 = n_perr;
        checkn("par_absent", p0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
